// File: rtl/video_test_source.sv
// Free-running video timing and test-pattern generator.
// Emits registered 24-bit RGB with active-high hs/vs/de, advancing only on ce_pix.
module video_test_source #(
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 16,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 12,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic        enable,
    input  logic [2:0]  pattern_sel,
    output logic [23:0] dout,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = $clog2(BAR_W);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);

    localparam logic [23:0] WHITE = 24'hFFFFFF;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [2:0]    pat_q, pat_d;
    logic [23:0]   dout_d;
    logic          hs_d, vs_d, de_d, fs_d;
    logic          h_wrap;
    logic [7:0]    h8, v8;
    logic [23:0]   pix;
    logic [23:0]   bar_rgb;

    assign h8 = 8'(hcnt_q);
    assign v8 = 8'(vcnt_q);

    always_comb begin
        case (bar_idx_q)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end

        // Bar width is a down-counter reloaded at line start; terminal count steps the bar index.
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q - 1'b1;
        if (h_wrap) begin
            bar_idx_d = '0;
            bar_cnt_d = BAR_LAST;
        end else if (bar_cnt_q == '0) begin
            bar_idx_d = bar_idx_q + 1'b1;
            bar_cnt_d = BAR_LAST;
        end

        fs_d  = (hcnt_q == '0) && (vcnt_q == '0);
        // The pixel (0,0) already uses the freshly latched selection.
        pat_d = fs_d ? pattern_sel : pat_q;
        de_d  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_d  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        vs_d  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);

        case (pat_d)
            3'd0:    pix = bar_rgb;
            3'd1:    pix = {h8, h8, h8};
            3'd2:    pix = (h8[0] ^ v8[0]) ? 24'h000000 : WHITE;
            3'd3:    pix = ((h8[3:0] == 4'd0) || (v8[3:0] == 4'd0) ||
                            (hcnt_q == H_ACT_LAST) || (vcnt_q == V_ACT_LAST)) ? WHITE : 24'h000000;
            3'd4:    pix = WHITE;
            3'd5:    pix = {16'h0000, v8};
            default: pix = 24'h000000;
        endcase
        dout_d = de_d ? pix : 24'h000000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            bar_cnt_q   <= BAR_LAST;
            bar_idx_q   <= '0;
            pat_q       <= '0;
            dout        <= '0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            de_out      <= 1'b0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            bar_cnt_q   <= BAR_LAST;
            bar_idx_q   <= '0;
            dout        <= '0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            de_out      <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce_pix) begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            pat_q       <= pat_d;
            dout        <= dout_d;
            hs_out      <= hs_d;
            vs_out      <= vs_d;
            de_out      <= de_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_video_test_source.sv
// Scoreboard bench for video_test_source on a 24x8 raster (16x4 active).
// The driver pushes the expected output of every issued pixel; the monitor pops and compares.
module tb_video_test_source;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_pix;
    logic        enable;
    logic [2:0]  pattern_sel;
    logic [23:0] dout;
    logic        hs_out, vs_out, de_out, frame_start;

    video_test_source #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .enable(enable),
        .pattern_sel(pattern_sel), .dout(dout), .hs_out(hs_out),
        .vs_out(vs_out), .de_out(de_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] val;
        int          h;
        int          v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int         mh = 0, mv = 0;
    logic [2:0] mpat = 3'd0;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [27:0] outs();
        return {dout, hs_out, vs_out, de_out, frame_start};
    endfunction

    task automatic chk(input string nm, input int h, input int v,
                       input logic [27:0] act, input logic [27:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s h=%0d v=%0d got=%07h expected=%07h", nm, h, v, act, exp);
        end
    endtask

    // Reference decode from raster position: {rgb, hs, vs, de, frame_start}.
    function automatic logic [27:0] model_px(input int h, input int v, input logic [2:0] p);
        logic        de, hs, vs, fs;
        logic [23:0] px;
        de = (h < 16) && (v < 4);
        hs = (h >= 18) && (h < 21);
        vs = (v >= 5) && (v < 7);
        fs = (h == 0) && (v == 0);
        px = 24'h0;
        if (de) begin
            case (p)
                3'd0: px = BARS[h / 2];
                3'd1: px = {3{8'(h)}};
                3'd2: px = (((h ^ v) & 1) == 0) ? 24'hFFFFFF : 24'h0;
                3'd3: px = ((h % 16 == 0) || (v % 16 == 0) || (h == 15) || (v == 3)) ? 24'hFFFFFF : 24'h0;
                3'd4: px = 24'hFFFFFF;
                3'd5: px = {16'h0, 8'(v)};
                default: px = 24'h0;
            endcase
        end
        return {px, hs, vs, de, fs};
    endfunction

    task automatic step(input logic ce, input logic en);
        ce_pix = ce;
        enable = en;
        @(posedge clk);
        if (en && ce) begin
            if (mh == 0 && mv == 0) mpat = pattern_sel;
            sb.push_back('{model_px(mh, mv, mpat), mh, mv});
            mh++;
            if (mh == 24) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end
        end else if (!en) begin
            mh = 0;
            mv = 0;
        end
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1);
    endtask

    // Monitor: classifies each clk edge and checks the outputs half a cycle later.
    logic        cap_rst, cap_en, cap_ce;
    logic [27:0] prev = '0;
    int          fs_gap = -1;
    exp_t        e;

    always begin
        @(posedge clk);
        cap_rst = reset_n;
        cap_en  = enable;
        cap_ce  = ce_pix;
        @(negedge clk);
        if (!cap_rst || !reset_n) begin
            fs_gap = -1;
        end else if (!cap_en) begin
            chk("idle_zero", 0, 0, outs(), 28'h0);
            fs_gap = -1;
        end else if (cap_ce) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 0, 0, outs(), 28'hFFFFFFF);
            end else begin
                e = sb.pop_front();
                chk("pixel", e.h, e.v, outs(), e.val);
            end
            if (fs_gap >= 0) fs_gap++;
            if (frame_start) begin
                if (fs_gap >= 0) chk("fs_period", 0, 0, 28'(fs_gap), 28'd192);
                fs_gap = 0;
            end
        end else begin
            chk("hold", mh, mv, outs(), prev);
        end
        prev = outs();
    end

    initial begin
        reset_n     = 1'b0;
        ce_pix      = 1'b0;
        enable      = 1'b0;
        pattern_sel = 3'd0;
        #12;
        chk("reset_state", 0, 0, outs(), 28'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Bars, then switch to flat white at line 2: applies from next frame only.
        run(48);
        pattern_sel = 3'd4;
        run(144);
        run(192);

        // Throttled bars: one ce every third clock.
        pattern_sel = 3'd0;
        for (int i = 0; i < 192; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
            step(1'b0, 1'b1);
        end

        // Drop enable at line 1 hcnt 7, then restart from (0,0).
        run(31);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        run(18);

        // Pixel h=18 has just been shown: hs is high; reset must clear it without a clock.
        @(negedge clk);
        #1;
        chk("hs_before_rst", 18, 0, 28'(hs_out), 28'd1);
        reset_n = 1'b0;
        #1;
        chk("hs_async_rst", 18, 0, 28'(hs_out), 28'd0);
        chk("all_async_rst", 18, 0, outs(), 28'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        mh = 0;
        mv = 0;
        mpat = 3'd0;

        pattern_sel = 3'd2; run(192);
        pattern_sel = 3'd3; run(192);
        pattern_sel = 3'd5; run(192);
        pattern_sel = 3'd1; run(192);
        pattern_sel = 3'd6; run(100);

        ce_pix = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 0, 0, 28'(sb.size()), 28'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
